// File: rtl/pkt_arb_pkg.sv
// Shared packet-framing definitions for the channel arbiter and the
// downstream framer. Both sides must agree on the 2-bit state encoding
// exposed on the arbiter's `state` port.
package pkt_arb_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_HEAD = 2'b01,
    STATE_DATA = 2'b10,
    STATE_TAIL = 2'b11
  } pkt_state_t;

endpackage

// File: rtl/pkt_channel_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports:
//   elig_i   - NUM_REQ-bit mask of requesters that may be chosen
//   rr_ptr_i - index at which the search starts (searching upward, wrapping)
//   sel_o    - index of the first eligible requester at or after rr_ptr_i
//   any_o    - high when at least one requester is eligible
module rr_picker
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         elig_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] sel_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  // Walk the offsets from farthest to nearest so the nearest eligible
  // requester (lowest offset from the pointer) is the last one written.
  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_i[(int'(rr_ptr_i) + k) % NUM_REQ]) begin
        sel_o = IW'((int'(rr_ptr_i) + k) % NUM_REQ);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_channel_arbiter.sv
// pkt_channel_arbiter: shares one packet channel between NUM_REQ
// requesters. A requester wins the channel with a head beat and keeps it
// until its tail beat (or until the packet hits MAX_BEATS and is cut
// short); ownership then rotates round-robin.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   req_valid/head/tail  - per-requester beat qualifiers (NUM_REQ bits)
//   req_data             - per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   req_ready            - per-requester accept strobe
//   out_valid/head/tail  - muxed channel beat toward the consumer
//   out_data             - muxed payload
//   out_ready            - consumer accepts the beat
//   grant                - one-hot packet owner while a packet is open
//   state                - framing state (pkt_state_t encoding)
//   abort                - one-cycle pulse after a packet was force-terminated
module pkt_channel_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_head,
  input  logic [NUM_REQ-1:0]         req_tail,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic                       out_head,
  output logic                       out_tail,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic [1:0]                 state,
  output logic                       abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);
  // Count value at which the next accepted beat is the last one allowed.
  localparam logic [CW-1:0] LIM_CNT = CW'(MAX_BEATS - 1);

  pkt_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          abort_q, abort_d;

  logic          arb;
  logic [IW-1:0] pick_sel;
  logic          pick_any;
  logic [IW-1:0] sel;
  logic          beat_valid;
  logic          at_limit;
  logic          xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .elig_i   (req_valid & req_head),
    .rr_ptr_i (rr_ptr_q),
    .sel_o    (pick_sel),
    .any_o    (pick_any)
  );

  // IDLE and TAIL are the cycles in which a new head may win the channel;
  // taking heads in TAIL gives zero-gap back-to-back packets.
  assign arb        = (state_q == STATE_IDLE) || (state_q == STATE_TAIL);
  assign sel        = arb ? pick_sel : owner_q;
  assign beat_valid = arb ? pick_any : req_valid[owner_q];
  assign at_limit   = !arb && (beat_cnt_q == LIM_CNT);

  assign out_valid  = !reset && beat_valid;
  assign out_head   = !reset && arb && pick_any;
  assign out_tail   = out_valid && (req_tail[sel] || at_limit);
  assign out_data   = reset ? '0 : req_data[int'(sel)*DATA_W +: DATA_W];
  assign xfer       = out_valid && out_ready;

  // Only the selected requester sees ready, and only for a beat the
  // channel would actually take, so a headless beat is never swallowed.
  always_comb begin
    req_ready = '0;
    if (out_valid && out_ready) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_comb begin
    grant = '0;
    if (!reset && !arb) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign state = state_q;
  assign abort = abort_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    abort_d    = 1'b0;
    if (arb) begin
      if (xfer) begin
        owner_d    = sel;
        rr_ptr_d   = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
        beat_cnt_d = CW'(1);
        state_d    = req_tail[sel] ? STATE_TAIL : STATE_HEAD;
      end else if (!pick_any) begin
        state_d = STATE_IDLE;
      end
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + CW'(1);
      state_d    = (req_tail[sel] || at_limit) ? STATE_TAIL : STATE_DATA;
      abort_d    = at_limit && !req_tail[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STATE_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      abort_q    <= abort_d;
    end
  end

endmodule
